uart_rx: RTL

UART receiver that deserialises one asynchronous 8N1-style frame (idle high, one start bit, DATA_WIDTH data bits LSB first, one stop bit) into a parallel word. It sits directly downstream of the UART transmit serial line, and its `rx_ready_o` drives the transmitter's ready input. It oversamples the line with the system clock and validates start and stop bits. It holds each received word until the consumer acknowledges it, and flags framing and overrun errors.

---
 rtl/uart_rx.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- asynchronous serial receiver (idle high, 1 start bit,
// DATA_WIDTH data bits LSB first, [optional even parity], 1 stop bit).
//
// The line is oversampled with clk. It passes through a 2-FF synchroniser
// and a 3-tap shift register, and each sample is the majority of the taps.
// A received word is held until the consumer pulses data_read_i.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one even-parity bit follows the data bits; adds parity_err_o
//   undefined -> frame is DATA_WIDTH+2 bits, no parity_err_o port
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz
//   BAUD_RATE    line bit rate
//   DATA_WIDTH   data bits per frame
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx_i          serial line (asynchronous, idle high)
//   data_read_i   single-cycle pulse, releases the held word and clears flags
//   data_o        last received word, stable while data_valid_o=1
//   data_valid_o  a word is held and unread
//   rx_ready_o    !data_valid_o, upstream transmitter may start a frame
//   frame_err_o   sticky, stop bit sampled low
//   overrun_o     sticky, a frame completed while a word was still held
//   parity_err_o  sticky, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  input  logic                  data_read_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  rx_ready_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);

  localparam int BIT  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = BIT / 2;
  localparam int CW   = (BIT > 1) ? $clog2(BIT) : 1;
  localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [1:0] r_sync;
  logic [2:0] r_tap;   // r_tap[0] is the newest sample

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // All ones so that leaving reset never looks like a falling edge.
      r_sync <= '1;
      r_tap  <= '1;
    end else begin
      r_sync <= {r_sync[0], rx_i};
      r_tap  <= {r_tap[1:0], r_sync[1]};
    end
  end

  logic w_bit;
  logic w_fall;

  assign w_bit  = (r_tap[0] & r_tap[1]) | (r_tap[0] & r_tap[2]) | (r_tap[1] & r_tap[2]);
  assign w_fall = r_tap[1] & ~r_tap[0];

  // ---------------------------------------------------------------------
  // Receive FSM and registered outputs
  // ---------------------------------------------------------------------
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_ovr;
`ifdef UART_RX_PARITY_EN
  logic                  r_par;
  logic                  r_perr;
`endif

  logic                  w_tick_bit;
  logic                  w_tick_half;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_tick_bit  = (r_cnt == C_BIT_LAST);
  assign w_tick_half = (r_cnt == C_HALF_LAST);

  // New sample enters at the MSB and shifts right, so the first bit on the
  // line (the LSB) ends up in bit 0 after DATA_WIDTH samples.
  always_comb begin
    w_shift_next                 = r_shreg >> 1;
    w_shift_next[DATA_WIDTH-1]   = w_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_cnt <= r_cnt + 1'b1;

      // Read clears first; a completion later in this block overrides it,
      // so a same-cycle completion keeps the word valid without overrun.
      if (data_read_i && r_valid) begin
        r_valid <= 1'b0;
        r_ferr  <= 1'b0;
        r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_perr  <= 1'b0;
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_tick_half) begin
            r_cnt <= '0;
            if (w_bit) begin
              // Line back high at mid start bit: treat as noise.
              r_state <= S_IDLE;
            end else begin
              r_idx   <= '0;
`ifdef UART_RX_PARITY_EN
              r_par   <= 1'b0;
`endif
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_tick_bit) begin
            r_cnt   <= '0;
            r_shreg <= w_shift_next;
`ifdef UART_RX_PARITY_EN
            r_par   <= r_par ^ w_bit;
`endif
            if (r_idx == C_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick_bit) begin
            r_cnt   <= '0;
            r_par   <= r_par ^ w_bit;
            r_state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (w_tick_bit) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_data  <= r_shreg;
            r_valid <= 1'b1;
            if (!w_bit) begin
              r_ferr <= 1'b1;
            end
            if (r_valid && !data_read_i) begin
              r_ovr <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (r_par) begin
              r_perr <= 1'b1;
            end
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign rx_ready_o   = ~r_valid;
  assign frame_err_o  = r_ferr;
  assign overrun_o    = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = r_perr;
`endif

endmodule
